uart_rx: RTL and testbench

Serial receiver for the UART path. It samples the asynchronous `i_rx` line using a 16x oversampling tick, reassembles 8N1 frames (LSB first), and presents each byte with a one-cycle valid strobe. It sits directly upstream of the ALU interface, which consumes `o_rx_data`/`o_rx_valid`. Frames that fail checking are flagged and never strobed as valid.

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/rx_sync.sv | 14 +
 rtl/uart_rx.sv | 103 ++++++++++
 tb/tb_uart_rx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART frame constants, one-hot receiver state encoding and counter sizing helper
package uart_rx_pkg;
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;
  localparam int NB_DATA_DEF    = 8;
  localparam int SB_TICK_DEF    = 16;
  localparam int OVERSAMPLE_DEF = 16;
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchroniser for an asynchronous input; i_clk, i_reset (async, high), i_d -> o_q; RST_VAL sets the reset level
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);
  logic meta;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) {o_q, meta} <= {2{RST_VAL}};
    else {o_q, meta} <= {meta, i_d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 (8E1 with UART_RX_PARITY_EN) receiver; i_clk, i_reset (async, high), i_s_tick, i_rx -> o_rx_data, o_rx_valid, o_frame_err, o_parity_err
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int SB_TICK    = SB_TICK_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_valid,
  output logic               o_frame_err,
  output logic               o_parity_err
);
  localparam int SW = cnt_w(OVERSAMPLE, SB_TICK);
  localparam int NW = cnt_w(NB_DATA, 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
  logic par_bad, par_err;
  assign o_parity_err = par_err;
`else
  localparam bit PARITY_EN = 1'b0;
  localparam logic par_bad = 1'b0;
  assign o_parity_err = 1'b0;
`endif
  state_t             state;
  logic [SW-1:0]      s_cnt;
  logic [NW-1:0]      n_cnt;
  logic [NB_DATA-1:0] shreg;
  logic               rx_s;
  rx_sync #(.RST_VAL(1'b1)) u_sync (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_rx), .o_q(rx_s));
  // IDLE reacts to the falling edge without waiting for a tick; everything else is tick-paced
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state       <= IDLE;
      s_cnt       <= '0;
      n_cnt       <= '0;
      shreg       <= '0;
      o_rx_data   <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      par_err     <= 1'b0;
`endif
    end else begin
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err     <= 1'b0;
`endif
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          s_cnt <= '0;
        end
        START: if (i_s_tick) begin
          if (s_cnt == S_MID) begin
            state <= rx_s ? IDLE : DATA;
            s_cnt <= '0;
            n_cnt <= '0;
          end else s_cnt <= s_cnt + 1'b1;
        end
        DATA: if (i_s_tick) begin
          if (s_cnt == S_BIT) begin
            shreg <= {rx_s, shreg[NB_DATA-1:1]};
            s_cnt <= '0;
            if (n_cnt == N_LAST) state <= PARITY_EN ? PARITY : STOP;
            else n_cnt <= n_cnt + 1'b1;
          end else s_cnt <= s_cnt + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (i_s_tick) begin
          if (s_cnt == S_BIT) begin
            par_bad <= ^{shreg, rx_s};
            s_cnt   <= '0;
            state   <= STOP;
          end else s_cnt <= s_cnt + 1'b1;
        end
`endif
        STOP: if (i_s_tick) begin
          if (s_cnt == S_STOP) begin
            state       <= IDLE;
            s_cnt       <= '0;
            o_rx_valid  <= rx_s && !par_bad;
            o_frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
            par_err     <= par_bad;
`endif
            if (rx_s && !par_bad) o_rx_data <= shreg;
          end else s_cnt <= s_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus against a frame-level expectation queue for uart_rx
module tb_uart_rx;
  localparam int NB   = 8;
  localparam int OS   = 16;
  localparam int SBT  = 16;
  localparam int TDIV = 2;
`ifdef UART_RX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  localparam int FT = OS / 2 + OS * (NB + PE) + SBT;
  localparam int FRAME_CYC = (OS * (1 + NB + PE) + SBT) * TDIV;
  typedef struct {
    logic          v;
    logic          f;
    logic          p;
    logic [NB-1:0] d;
  } ev_t;
  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_rx = 1'b1;
  logic          i_s_tick;
  logic [NB-1:0] o_rx_data;
  logic          o_rx_valid, o_frame_err, o_parity_err;
  int            div = 0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            mon = 1'b0;
  logic [NB-1:0] last_good = '0;
  ev_t           exp_q[$];
  ev_t           cur;
  int            strobe_t[$];
  uart_rx #(.NB_DATA(NB), .SB_TICK(SBT), .OVERSAMPLE(OS)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_s_tick(i_s_tick), .i_rx(i_rx),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_frame_err(o_frame_err), .o_parity_err(o_parity_err)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) div <= (div == TDIV - 1) ? 0 : div + 1;
  assign i_s_tick = (div == 0);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge i_clk) begin
    cyc++;
    if (mon && !i_reset) begin
      if (o_rx_valid || o_frame_err || o_parity_err) begin
        strobe_t.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_strobe", {o_rx_valid, o_frame_err, o_parity_err}, 3'b000);
        else begin
          cur = exp_q.pop_front();
          chk("strobe_kind", {o_rx_valid, o_frame_err, o_parity_err}, {cur.v, cur.f, cur.p});
          if (cur.v) last_good = cur.d;
        end
      end
      chk("rx_data_hold", o_rx_data, last_good);
    end
  end
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge i_clk);
      while (!i_s_tick) @(posedge i_clk);
    end
    #1;
  endtask
  task automatic drive(input logic b, input int n);
    i_rx = b;
    ticks(n);
  endtask
  task automatic send(input logic [NB-1:0] d, input bit stop_ok, input bit par_bad);
    exp_q.push_back('{v: stop_ok && !(PE != 0 && par_bad), f: !stop_ok, p: PE != 0 && par_bad, d: d});
    drive(1'b0, OS);
    for (int i = 0; i < NB; i++) drive(d[i], OS);
    if (PE != 0) drive(^d ^ par_bad, OS);
    if (stop_ok) drive(1'b1, SBT);
    else begin
      drive(1'b0, SBT - 4);
      drive(1'b1, 20);
    end
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge i_clk);
      n++;
    end
    if (n > 0) #1;
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, o_rx_data, 0);
    chk({tag, "_valid"}, o_rx_valid, 0);
    chk({tag, "_ferr"}, o_frame_err, 0);
    chk({tag, "_perr"}, o_parity_err, 0);
  endtask
  initial begin
    #2 i_reset = 1'b1;
    #1 chk_zero("reset");
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    mon = 1'b1;
    ticks(20);
    send(8'h55, 1'b1, 1'b0);
    drain();
    chk("frame_55", o_rx_data, 8'h55);
    strobe_t.delete();
    send(8'hFF, 1'b1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    drain();
    chk("b2b_count", strobe_t.size(), 2);
    if (strobe_t.size() == 2) chk("b2b_gap", strobe_t[1] - strobe_t[0], FRAME_CYC);
    chk("frame_00", o_rx_data, 8'h00);
    drive(1'b0, 4);
    drive(1'b1, 16);
    send(8'h3C, 1'b1, 1'b0);
    drain();
    chk("glitch_then_3c", o_rx_data, 8'h3C);
    send(8'h12, 1'b1, 1'b0);
    send(8'hA5, 1'b0, 1'b0);
    drain();
    chk("frame_err_hold", o_rx_data, 8'h12);
    drive(1'b0, OS);
    for (int i = 0; i < 3; i++) drive(1'(8'h81 >> i), OS);
    i_rx = 1'b0;
    ticks(5);
    i_reset = 1'b1;
    #1 chk_zero("reset_mid");
    last_good = '0;
    exp_q.delete();
    i_rx = 1'b1;
    ticks(4);
    i_reset = 1'b0;
    ticks(10);
    send(8'h81, 1'b1, 1'b0);
    drain();
    chk("frame_81", o_rx_data, 8'h81);
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0);
    drain();
    chk("parity_good_07", o_rx_data, 8'h07);
    send(8'h3C, 1'b1, 1'b1);
    drain();
    chk("parity_bad_hold", o_rx_data, 8'h07);
`endif
    exp_q.push_back('{v: 1'b0, f: 1'b1, p: 1'b0, d: '0});
    exp_q.push_back('{v: 1'b0, f: 1'b1, p: 1'b0, d: '0});
    exp_q.push_back('{v: 1'b1, f: 1'b0, p: 1'b0, d: '0});
    drive(1'b0, 3 * FT - 8);
    drive(1'b1, 40);
    drain();
    chk("stuck_low_recover", o_rx_data, 8'h00);
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        drive(1'b0, $urandom_range(1, 6));
        drive(1'b1, 16);
      end else begin
        send(NB'($urandom), $urandom_range(0, 3) != 0, PE != 0 && $urandom_range(0, 3) == 0);
        drive(1'b1, $urandom_range(0, 12));
      end
      drain();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
